// File: rtl/bank_ram_pkg.sv
// Shared types and helpers for the banked RAM front-end and its response FIFO.
package bank_ram_pkg;

  typedef enum logic {
    SHARED   = 1'b0,
    PER_BANK = 1'b1
  } addr_mode_e;

  localparam int DEF_BANKS  = 5;
  localparam int DEF_DATA_W = 32;

  // Default-geometry response record; the controller declares a parameter-sized copy.
  typedef struct packed {
    logic [DEF_BANKS*DEF_DATA_W-1:0] data;
    logic [DEF_BANKS-1:0]            mask;
  } rsp_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bank_rsp_fifo.sv
// Synchronous FIFO with a registered head word, full/empty flags and an occupancy count.
module bank_rsp_fifo
  import bank_ram_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dout;
  logic             w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push = i_push && (r_count != DEPTH_C);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Head register reloads from the write port when the queue is (or becomes) one deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push && ((r_count == '0) || ((r_count == ONE_C) && w_pop)))
        r_dout <= i_din;
      else if (w_pop && (r_count > ONE_C))
        r_dout <= r_mem[ptr_inc(r_rptr)];
    end
  end

  assign o_dout  = r_dout;
  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/bank_ram_ctrl.sv
// Banked RAM front-end: SIMD/per-bank addressing, fixed-latency read tags and a
// credit-limited in-order response FIFO with backpressure.
module bank_ram_ctrl
  import bank_ram_pkg::*;
#(
  parameter int NUM_BANKS   = 5,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_rw,
  input  addr_mode_e                     cmd_mode,
  input  logic [NUM_BANKS-1:0]           cmd_mask,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] cmd_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] cmd_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rsp_data,
  output logic [NUM_BANKS-1:0]           rsp_mask,
  output logic                           busy,
  output logic [NUM_BANKS-1:0]           ram_en,
  output logic [NUM_BANKS-1:0]           ram_we,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] ram_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] ram_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] ram_rdata
);

  localparam int CNT_W = cnt_width(RSP_DEPTH);
  localparam int RSP_W = NUM_BANKS*DATA_WIDTH + NUM_BANKS;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  typedef struct packed {
    logic [NUM_BANKS*DATA_WIDTH-1:0] data;
    logic [NUM_BANKS-1:0]            mask;
  } rsp_p_t;

  logic [CNT_W-1:0]                      r_out;
  logic [RAM_LATENCY:1]                  r_vld_pipe;
  logic [RAM_LATENCY:1][NUM_BANKS-1:0]   r_tag_pipe;
  logic                                  w_fire, w_rd_fire, w_pop;
  logic [NUM_BANKS*DATA_WIDTH-1:0]       w_rd_masked;
  rsp_p_t                                w_push_rsp, w_head;
  logic                                  w_fifo_full, w_fifo_empty;
  logic [CNT_W-1:0]                      w_unused_fifo_count;

  assign cmd_ready = !rst && (r_out < DEPTH_C);
  assign w_fire    = cmd_valid && cmd_ready;
  assign w_rd_fire = w_fire && !cmd_rw;
  assign ram_en    = w_fire ? cmd_mask : '0;
  assign ram_we    = (w_fire && cmd_rw) ? cmd_mask : '0;
  assign ram_wdata = cmd_wdata;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign ram_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = (cmd_mode == PER_BANK) ?
      cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : cmd_addr[0 +: ADDR_WIDTH];
    assign w_rd_masked[i*DATA_WIDTH +: DATA_WIDTH] =
      ram_rdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_tag_pipe[RAM_LATENCY][i]}};
  end

  assign w_push_rsp = '{data: w_rd_masked, mask: r_tag_pipe[RAM_LATENCY]};

  // Tag stage k is valid in the k-th cycle after the read fired, aligned with ram_rdata at k = RAM_LATENCY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_rd_fire;
      r_tag_pipe[1] <= cmd_mask;
      for (int k = 2; k <= RAM_LATENCY; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_tag_pipe[k] <= r_tag_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= r_out + CNT_W'(w_rd_fire) - CNT_W'(w_pop);
  end

  bank_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_vld_pipe[RAM_LATENCY] && !w_fifo_full),
    .i_pop   (w_pop),
    .i_din   (w_push_rsp),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_unused_fifo_count)
  );

  assign rsp_valid = !w_fifo_empty && !rst;
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_data  = w_head.data;
  assign rsp_mask  = w_head.mask;
  assign busy      = !rst && (r_out != '0);

endmodule
